// File: rtl/membus_cycle_ctl_if.sv
// rtl/membus_cycle_ctl_if.sv - memory bus signal bundle between cycle controller and memory
//
// Purpose: groups the memory-side handshake and data signals of membus_cycle_ctl.
// Ports (master = cycle controller, slave = memory):
//   membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs  master -> slave, 1 bit each
//   membus_ma       master -> slave, AW bits, relocated address
//   membus_mb_out   master -> slave, DW bits, write data (zero outside wr_rs)
//   membus_addr_ack, membus_rd_rs  slave -> master, 1 bit each
//   membus_mb_in    slave -> master, DW bits, read data
interface membus_cycle_ctl_if #(
    parameter int AW = 18,
    parameter int DW = 36
);
    logic            membus_rq_cyc;
    logic            membus_rd_rq;
    logic            membus_wr_rq;
    logic            membus_wr_rs;
    logic [0:AW-1]   membus_ma;
    logic [0:DW-1]   membus_mb_out;
    logic            membus_addr_ack;
    logic            membus_rd_rs;
    logic [0:DW-1]   membus_mb_in;

    modport master (
        output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
        output membus_ma, membus_mb_out,
        input  membus_addr_ack, membus_rd_rs, membus_mb_in
    );

    modport slave (
        input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
        input  membus_ma, membus_mb_out,
        output membus_addr_ack, membus_rd_rs, membus_mb_in
    );
endinterface

// File: rtl/membus_cycle_ctl.sv
// rtl/membus_cycle_ctl.sv - memory bus cycle controller with relocation, stop and NXM timeout
//
// Purpose: runs one read, write or read-pause-write memory cycle per request,
// relocating/protecting the upper address field, honouring stop switches and
// timing out on non-existent memory.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_rd/req_wr/req_rdwr       request strobes (rdwr > rd > wr), taken in IDLE only
//   wr_go                        starts the write half of a read-pause-write
//   addr, wdata                  processor address and write data
//   inh_rel, rlr, pr             relocation inhibit, relocation and protection registers
//   mem_stop, addr_stop, addr_sw, mem_cont  stop switches and continue
//   mem_disable                  hang on NXM instead of recovering
//   bus                          memory bus (master modport)
//   rdata                        read data register
//   busy, stopped                status levels
//   done, nxm, illeg_addr        one-clock status pulses
module membus_cycle_ctl #(
    parameter int DW      = 36,
    parameter int AW      = 18,
    parameter int RW      = 8,
    parameter int NXM_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic                req_rdwr,
    input  logic                wr_go,
    input  logic [0:AW-1]       addr,
    input  logic [0:DW-1]       wdata,
    input  logic                inh_rel,
    input  logic [0:RW-1]       rlr,
    input  logic [0:RW-1]       pr,
    input  logic                mem_stop,
    input  logic                addr_stop,
    input  logic [0:AW-1]       addr_sw,
    input  logic                mem_cont,
    input  logic                mem_disable,
    membus_cycle_ctl_if.master  bus,
    output logic [0:DW-1]       rdata,
    output logic                busy,
    output logic                stopped,
    output logic                done,
    output logic                nxm,
    output logic                illeg_addr
);
    localparam int CW = $clog2(NXM_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NXM_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NXM_CYC);

    typedef enum logic [2:0] {IDLE, STOP, RQ, RDWAIT, PAUSE, WRRS} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_RDWR} op_t;

    state_t         state;
    op_t            op;
    op_t            req_op;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           expire;
    logic           hang;       // NXM with mem_disable: frozen until reset
    logic           nxm_hit;    // NXM recovered in RQ: RDWAIT completes with zero data
    logic [0:DW-1]  wdata_q;
    logic [0:RW-1]  rel_field;
    logic           req_any;
    logic           rd_done;

    assign req_any   = req_rd | req_wr | req_rdwr;
    assign rel_field = addr[0:RW-1] + (inh_rel ? {RW{1'b0}} : rlr);
    // Counter saturates one past the last count so the timeout fires only once per cycle.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign expire    = (cnt == CNT_LAST);
    assign rd_done   = bus.membus_rd_rs | nxm_hit | (expire & ~mem_disable);

    always_comb begin
        req_op = OP_WR;
        if (req_rdwr)    req_op = OP_RDWR;
        else if (req_rd) req_op = OP_RD;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            op                <= OP_RD;
            cnt               <= '0;
            hang              <= 1'b0;
            nxm_hit           <= 1'b0;
            wdata_q           <= '0;
            rdata             <= '0;
            busy              <= 1'b0;
            stopped           <= 1'b0;
            done              <= 1'b0;
            nxm               <= 1'b0;
            illeg_addr        <= 1'b0;
            bus.membus_rq_cyc <= 1'b0;
            bus.membus_rd_rq  <= 1'b0;
            bus.membus_wr_rq  <= 1'b0;
            bus.membus_wr_rs  <= 1'b0;
            bus.membus_ma     <= '0;
            bus.membus_mb_out <= '0;
        end else begin
            done       <= 1'b0;
            nxm        <= 1'b0;
            illeg_addr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        op            <= req_op;
                        bus.membus_ma <= {rel_field, addr[RW:AW-1]};
                        rdata         <= '0;
                        wdata_q       <= wdata;
                        cnt           <= '0;
                        hang          <= 1'b0;
                        nxm_hit       <= 1'b0;
                        if (!inh_rel && (addr[0:RW-1] > pr)) begin
                            illeg_addr <= 1'b1;
                            done       <= 1'b1;
                        end else if (mem_stop || (addr_stop && (addr == addr_sw))) begin
                            state   <= STOP;
                            stopped <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state             <= RQ;
                            busy              <= 1'b1;
                            bus.membus_rq_cyc <= 1'b1;
                            bus.membus_rd_rq  <= (req_op != OP_WR);
                            bus.membus_wr_rq  <= (req_op == OP_WR);
                        end
                    end
                end
                STOP: begin
                    if (mem_cont) begin
                        state             <= RQ;
                        stopped           <= 1'b0;
                        cnt               <= '0;
                        bus.membus_rq_cyc <= 1'b1;
                        bus.membus_rd_rq  <= (op != OP_WR);
                        bus.membus_wr_rq  <= (op == OP_WR);
                    end
                end
                RQ: begin
                    if (!hang) begin
                        cnt <= cnt_inc;
                        // A simultaneous rd_rs is ignored here; it is only sampled in RDWAIT.
                        if (!bus.membus_addr_ack && expire) begin
                            nxm     <= 1'b1;
                            hang    <= mem_disable;
                            nxm_hit <= ~mem_disable;
                        end
                        if (bus.membus_addr_ack || (expire && !mem_disable)) begin
                            if (op == OP_WR) begin
                                state             <= WRRS;
                                bus.membus_wr_rq  <= 1'b0;
                                bus.membus_wr_rs  <= 1'b1;
                                bus.membus_mb_out <= wdata_q;
                            end else begin
                                state <= RDWAIT;
                            end
                        end
                    end
                end
                RDWAIT: begin
                    if (!hang) begin
                        cnt <= cnt_inc;
                        if (!bus.membus_rd_rs && !nxm_hit && expire) begin
                            nxm  <= 1'b1;
                            hang <= mem_disable;
                        end
                        if (bus.membus_rd_rs) begin
                            rdata <= bus.membus_mb_in;
                        end
                        if (rd_done) begin
                            bus.membus_rd_rq <= 1'b0;
                            if (op == OP_RDWR) begin
                                state <= PAUSE;
                            end else begin
                                state             <= IDLE;
                                busy              <= 1'b0;
                                done              <= 1'b1;
                                bus.membus_rq_cyc <= 1'b0;
                            end
                        end
                    end
                end
                PAUSE: begin
                    // The address stays acknowledged from the read half; no second ack.
                    if (wr_go) begin
                        state             <= WRRS;
                        bus.membus_wr_rs  <= 1'b1;
                        bus.membus_mb_out <= wdata;
                    end
                end
                WRRS: begin
                    state             <= IDLE;
                    busy              <= 1'b0;
                    done              <= 1'b1;
                    bus.membus_rq_cyc <= 1'b0;
                    bus.membus_wr_rs  <= 1'b0;
                    bus.membus_mb_out <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_membus_cycle_ctl.sv
// tb/tb_membus_cycle_ctl.sv - directed self-checking bench for membus_cycle_ctl
module tb_membus_cycle_ctl;
    localparam int DW = 36;
    localparam int AW = 18;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req_rd, req_wr, req_rdwr, wr_go;
    logic [0:AW-1]   addr;
    logic [0:DW-1]   wdata;
    logic            inh_rel;
    logic [0:RW-1]   rlr, pr;
    logic            mem_stop, addr_stop, mem_cont, mem_disable;
    logic [0:AW-1]   addr_sw;
    logic [0:DW-1]   rdata;
    logic            busy, stopped, done, nxm, illeg_addr;

    int n_cmp = 0;
    int n_bad = 0;

    membus_cycle_ctl_if #(.AW(AW), .DW(DW)) bus ();

    membus_cycle_ctl #(.DW(DW), .AW(AW), .RW(RW), .NXM_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_rdwr(req_rdwr), .wr_go(wr_go),
        .addr(addr), .wdata(wdata), .inh_rel(inh_rel), .rlr(rlr), .pr(pr),
        .mem_stop(mem_stop), .addr_stop(addr_stop), .addr_sw(addr_sw),
        .mem_cont(mem_cont), .mem_disable(mem_disable),
        .bus(bus),
        .rdata(rdata), .busy(busy), .stopped(stopped), .done(done),
        .nxm(nxm), .illeg_addr(illeg_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_rd = 0; req_wr = 0; req_rdwr = 0; wr_go = 0;
        addr = '0; wdata = '0; inh_rel = 1; rlr = '0; pr = '0;
        mem_stop = 0; addr_stop = 0; addr_sw = '0; mem_cont = 0; mem_disable = 0;
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 0; bus.membus_mb_in = '0;
        tick(); tick();
        reset_n = 1'b1;
        n_cmp++; if ({busy, stopped, done, nxm, illeg_addr, bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq, bus.membus_wr_rs} !== 9'b0) begin n_bad++; $display("FAIL reset_status: got %b want 0", {busy, stopped, done, nxm, illeg_addr, bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq, bus.membus_wr_rs}); end
        n_cmp++; if ({rdata, bus.membus_ma, bus.membus_mb_out} !== '0) begin n_bad++; $display("FAIL reset_data: got %o/%o/%o want 0", rdata, bus.membus_ma, bus.membus_mb_out); end
    endtask

    task automatic test_read();
        inh_rel = 1; addr = 18'o001234; req_rd = 1;
        tick();
        req_rd = 0;
        n_cmp++; if ({bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq, busy} !== 4'b1101) begin n_bad++; $display("FAIL read_rq: got %b want 1101", {bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq, busy}); end
        n_cmp++; if (bus.membus_ma !== 18'o001234) begin n_bad++; $display("FAIL read_ma: got %o want 001234", bus.membus_ma); end
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o123456701234;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if (rdata !== 36'o123456701234) begin n_bad++; $display("FAIL read_data: got %o want 123456701234", rdata); end
        n_cmp++; if ({done, bus.membus_rq_cyc, busy} !== 3'b100) begin n_bad++; $display("FAIL read_done: got %b want 100", {done, bus.membus_rq_cyc, busy}); end
        tick();
        n_cmp++; if ({done, bus.membus_rq_cyc} !== 2'b00) begin n_bad++; $display("FAIL read_done_pulse: got %b want 00", {done, bus.membus_rq_cyc}); end
    endtask

    task automatic test_ack_rs_same();
        addr = 18'o000100; req_rd = 1; req_wr = 1;
        tick();
        req_rd = 0; req_wr = 0;
        n_cmp++; if ({bus.membus_rd_rq, bus.membus_wr_rq} !== 2'b10) begin n_bad++; $display("FAIL prio_rd_over_wr: got %b want 10", {bus.membus_rd_rq, bus.membus_wr_rq}); end
        bus.membus_addr_ack = 1; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o111;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 0;
        tick();
        n_cmp++; if ({busy, done, rdata} !== {1'b1, 1'b0, 36'o0}) begin n_bad++; $display("FAIL ack_rs_same: got busy=%b done=%b rdata=%o want 1 0 0", busy, done, rdata); end
        bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o222;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if ({done, rdata} !== {1'b1, 36'o222}) begin n_bad++; $display("FAIL ack_rs_later: got done=%b rdata=%o want 1 222", done, rdata); end
        tick();
    endtask

    task automatic test_write();
        addr = 18'o000321; wdata = 36'o777000111222; req_wr = 1;
        tick();
        req_wr = 0; wdata = '0;
        n_cmp++; if ({bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq} !== 3'b101) begin n_bad++; $display("FAIL write_rq: got %b want 101", {bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq}); end
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0;
        n_cmp++; if ({bus.membus_wr_rs, bus.membus_mb_out} !== {1'b1, 36'o777000111222}) begin n_bad++; $display("FAIL write_rs: got %b %o want 1 777000111222", bus.membus_wr_rs, bus.membus_mb_out); end
        tick();
        n_cmp++; if ({bus.membus_wr_rs, bus.membus_rq_cyc, done, busy, bus.membus_mb_out} !== {4'b0010, 36'o0}) begin n_bad++; $display("FAIL write_end: got rs=%b cyc=%b done=%b busy=%b mb=%o want 0 0 1 0 0", bus.membus_wr_rs, bus.membus_rq_cyc, done, busy, bus.membus_mb_out); end
        tick();
    endtask

    task automatic test_reloc();
        inh_rel = 0; rlr = 8'o010; pr = 8'o004;
        addr = {8'o003, 10'o1234}; req_rd = 1;
        tick();
        req_rd = 0;
        n_cmp++; if (bus.membus_ma !== {8'o013, 10'o1234}) begin n_bad++; $display("FAIL reloc_ma: got %o want %o", bus.membus_ma, {8'o013, 10'o1234}); end
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o55;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if ({done, rdata} !== {1'b1, 36'o55}) begin n_bad++; $display("FAIL reloc_done: got %b %o want 1 55", done, rdata); end
        tick();
        addr = {8'o005, 10'o0}; req_rd = 1;
        tick();
        req_rd = 0;
        n_cmp++; if ({illeg_addr, done, bus.membus_rq_cyc, busy} !== 4'b1100) begin n_bad++; $display("FAIL illeg: got %b want 1100", {illeg_addr, done, bus.membus_rq_cyc, busy}); end
        tick();
        n_cmp++; if ({illeg_addr, done, bus.membus_rq_cyc, busy} !== 4'b0000) begin n_bad++; $display("FAIL illeg_after: got %b want 0000", {illeg_addr, done, bus.membus_rq_cyc, busy}); end
        inh_rel = 1;
    endtask

    task automatic test_rdwr();
        logic cyc_all;
        addr = 18'o000777; req_rdwr = 1; req_rd = 1;
        tick();
        req_rdwr = 0; req_rd = 0;
        n_cmp++; if ({bus.membus_rd_rq, bus.membus_wr_rq} !== 2'b10) begin n_bad++; $display("FAIL rdwr_rq: got %b want 10", {bus.membus_rd_rq, bus.membus_wr_rq}); end
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o5;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if ({bus.membus_rq_cyc, bus.membus_rd_rq, done, busy, rdata} !== {4'b1001, 36'o5}) begin n_bad++; $display("FAIL rdwr_pause: got cyc=%b rdrq=%b done=%b busy=%b rdata=%o want 1 0 0 1 5", bus.membus_rq_cyc, bus.membus_rd_rq, done, busy, rdata); end
        cyc_all = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_rd = (i == 2);
            tick();
            cyc_all = cyc_all & bus.membus_rq_cyc & ~bus.membus_wr_rs & ~done;
        end
        req_rd = 0;
        n_cmp++; if (cyc_all !== 1'b1) begin n_bad++; $display("FAIL rdwr_hold: got %b want 1", cyc_all); end
        wr_go = 1; wdata = 36'o1000;
        tick();
        wr_go = 0; wdata = '0;
        n_cmp++; if ({bus.membus_wr_rs, bus.membus_rq_cyc, bus.membus_mb_out} !== {2'b11, 36'o1000}) begin n_bad++; $display("FAIL rdwr_wrrs: got rs=%b cyc=%b mb=%o want 1 1 1000", bus.membus_wr_rs, bus.membus_rq_cyc, bus.membus_mb_out); end
        tick();
        n_cmp++; if ({bus.membus_wr_rs, bus.membus_rq_cyc, done, bus.membus_mb_out} !== {3'b001, 36'o0}) begin n_bad++; $display("FAIL rdwr_end: got rs=%b cyc=%b done=%b mb=%o want 0 0 1 0", bus.membus_wr_rs, bus.membus_rq_cyc, done, bus.membus_mb_out); end
        tick();
    endtask

    task automatic test_nxm();
        int seen;
        int pulses;
        mem_disable = 0; addr = 18'o000042; req_rd = 1;
        bus.membus_mb_in = '1;
        tick();
        req_rd = 0;
        seen = 0;
        for (int i = 1; i <= 20 && seen == 0; i++) begin
            tick();
            if (nxm) seen = i;
        end
        n_cmp++; if (seen !== 8) begin n_bad++; $display("FAIL nxm_time: got %0d want 8", seen); end
        tick();
        n_cmp++; if ({done, busy, nxm, bus.membus_rq_cyc, rdata} !== {4'b1000, 36'o0}) begin n_bad++; $display("FAIL nxm_recover: got done=%b busy=%b nxm=%b cyc=%b rdata=%o want 1 0 0 0 0", done, busy, nxm, bus.membus_rq_cyc, rdata); end
        tick();
        mem_disable = 1; req_rd = 1;
        tick();
        req_rd = 0;
        seen = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (nxm) begin pulses++; if (seen == 0) seen = i; end
            bus.membus_addr_ack = (i >= 12);
        end
        bus.membus_addr_ack = 0;
        n_cmp++; if ({seen, pulses} !== {32'd8, 32'd1}) begin n_bad++; $display("FAIL nxm_hang_pulse: got at=%0d n=%0d want 8 1", seen, pulses); end
        n_cmp++; if ({busy, bus.membus_rq_cyc, done} !== 3'b110) begin n_bad++; $display("FAIL nxm_hang: got %b want 110", {busy, bus.membus_rq_cyc, done}); end
        reset_n = 0;
        tick();
        reset_n = 1; mem_disable = 0;
        n_cmp++; if ({busy, bus.membus_rq_cyc} !== 2'b00) begin n_bad++; $display("FAIL nxm_reset: got %b want 00", {busy, bus.membus_rq_cyc}); end
    endtask

    task automatic test_addr_stop();
        addr_stop = 1; addr_sw = 18'o004321; addr = 18'o004321; req_rd = 1;
        tick();
        req_rd = 0;
        n_cmp++; if ({stopped, busy, bus.membus_rq_cyc} !== 3'b110) begin n_bad++; $display("FAIL stop_enter: got %b want 110", {stopped, busy, bus.membus_rq_cyc}); end
        tick(); tick();
        n_cmp++; if ({stopped, bus.membus_rq_cyc} !== 2'b10) begin n_bad++; $display("FAIL stop_hold: got %b want 10", {stopped, bus.membus_rq_cyc}); end
        mem_cont = 1;
        tick();
        mem_cont = 0;
        n_cmp++; if ({stopped, bus.membus_rq_cyc, bus.membus_rd_rq} !== 3'b011) begin n_bad++; $display("FAIL stop_cont: got %b want 011", {stopped, bus.membus_rq_cyc, bus.membus_rd_rq}); end
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o7070;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if ({done, rdata} !== {1'b1, 36'o7070}) begin n_bad++; $display("FAIL stop_done: got %b %o want 1 7070", done, rdata); end
        addr_stop = 0;
        tick();
    endtask

    task automatic test_reset_pause();
        addr = 18'o000600; req_rdwr = 1;
        tick();
        req_rdwr = 0;
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o3;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if ({bus.membus_rq_cyc, busy, rdata} !== {2'b11, 36'o3}) begin n_bad++; $display("FAIL pause_reach: got cyc=%b busy=%b rdata=%o want 1 1 3", bus.membus_rq_cyc, busy, rdata); end
        reset_n = 0;
        tick();
        reset_n = 1;
        n_cmp++; if ({busy, stopped, done, nxm, illeg_addr, bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_wr_rq, bus.membus_wr_rs} !== 9'b0 || {rdata, bus.membus_ma, bus.membus_mb_out} !== '0) begin n_bad++; $display("FAIL pause_reset: got busy=%b cyc=%b rdata=%o ma=%o want all 0", busy, bus.membus_rq_cyc, rdata, bus.membus_ma); end
        addr = 18'o000601; req_rd = 1;
        tick();
        req_rd = 0;
        n_cmp++; if ({bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_ma} !== {2'b11, 18'o000601}) begin n_bad++; $display("FAIL pause_newreq: got cyc=%b rdrq=%b ma=%o want 1 1 000601", bus.membus_rq_cyc, bus.membus_rd_rq, bus.membus_ma); end
        bus.membus_addr_ack = 1;
        tick();
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 1; bus.membus_mb_in = 36'o4;
        tick();
        bus.membus_rd_rs = 0;
        n_cmp++; if ({done, rdata} !== {1'b1, 36'o4}) begin n_bad++; $display("FAIL pause_newdone: got %b %o want 1 4", done, rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_ack_rs_same();
        test_write();
        test_reloc();
        test_rdwr();
        test_nxm();
        test_addr_stop();
        test_reset_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
